// File: rtl/tl_d_beat_tracker_pkg.sv
// Shared TileLink D/E channel constants, field widths and the beat-count helper
// used by the D-channel beat tracker.
package tl_d_pkg;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] GRANT           = 3'd4;
  localparam logic [2:0] GRANT_DATA      = 3'd5;
  localparam logic [2:0] RELEASE_ACK     = 3'd6;

  localparam int LOG2_BEAT_BYTES = 3;

  localparam int OPCODE_W = 3;
  localparam int PARAM_W  = 2;
  localparam int SIZE_W   = 4;
  localparam int SOURCE_W = 5;
  localparam int SINK_W   = 3;
  localparam int DATA_W   = 64;

  // Beats minus one for a response; only data-bearing opcodes span several beats.
  // Wide enough for the largest encodable size so illegal sizes are not aliased.
  function automatic logic [15:0] num_beats1(input logic [OPCODE_W-1:0] opcode,
                                             input logic [SIZE_W-1:0]   size);
    logic [15:0] r;
    r = '0;
    if ((opcode == ACCESS_ACK_DATA || opcode == GRANT_DATA) &&
        size > SIZE_W'(LOG2_BEAT_BYTES)) begin
      r = (16'd1 << (size - SIZE_W'(LOG2_BEAT_BYTES))) - 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tl_d_beat_tracker_if.sv
// D-channel (upstream and client side) plus E-channel signal bundle of the beat tracker.
// All handshakes: a transfer happens on a rising clock edge where valid & ready are both 1;
// valid never waits on ready, and payload is only meaningful while valid is 1.
interface tl_d_beat_tracker_if;
  import tl_d_pkg::*;

  logic                in_d_valid;
  logic                in_d_ready;
  logic [OPCODE_W-1:0] in_d_bits_opcode;
  logic [PARAM_W-1:0]  in_d_bits_param;
  logic [SIZE_W-1:0]   in_d_bits_size;
  logic [SOURCE_W-1:0] in_d_bits_source;
  logic [SINK_W-1:0]   in_d_bits_sink;
  logic                in_d_bits_denied;
  logic [DATA_W-1:0]   in_d_bits_data;
  logic                in_d_bits_corrupt;

  logic                out_d_valid;
  logic                out_d_ready;
  logic [OPCODE_W-1:0] out_d_bits_opcode;
  logic [PARAM_W-1:0]  out_d_bits_param;
  logic [SIZE_W-1:0]   out_d_bits_size;
  logic [SOURCE_W-1:0] out_d_bits_source;
  logic [SINK_W-1:0]   out_d_bits_sink;
  logic                out_d_bits_denied;
  logic [DATA_W-1:0]   out_d_bits_data;
  logic                out_d_bits_corrupt;
  logic                out_d_first;
  logic                out_d_last;
  logic [2:0]          out_d_beat;

  logic                io_e_valid;
  logic                io_e_ready;
  logic [SINK_W-1:0]   io_e_bits_sink;

  // Environment side: upstream queue, downstream client and E-channel consumer.
  modport master (
    output in_d_valid, in_d_bits_opcode, in_d_bits_param, in_d_bits_size,
           in_d_bits_source, in_d_bits_sink, in_d_bits_denied, in_d_bits_data,
           in_d_bits_corrupt, out_d_ready, io_e_ready,
    input  in_d_ready, out_d_valid, out_d_bits_opcode, out_d_bits_param,
           out_d_bits_size, out_d_bits_source, out_d_bits_sink, out_d_bits_denied,
           out_d_bits_data, out_d_bits_corrupt, out_d_first, out_d_last,
           out_d_beat, io_e_valid, io_e_bits_sink
  );

  // Tracker side.
  modport slave (
    input  in_d_valid, in_d_bits_opcode, in_d_bits_param, in_d_bits_size,
           in_d_bits_source, in_d_bits_sink, in_d_bits_denied, in_d_bits_data,
           in_d_bits_corrupt, out_d_ready, io_e_ready,
    output in_d_ready, out_d_valid, out_d_bits_opcode, out_d_bits_param,
           out_d_bits_size, out_d_bits_source, out_d_bits_sink, out_d_bits_denied,
           out_d_bits_data, out_d_bits_corrupt, out_d_first, out_d_last,
           out_d_beat, io_e_valid, io_e_bits_sink
  );

endinterface

// File: rtl/tl_d_beat_tracker_e_slot.sv
// One-entry GrantAck holding register. A load in the same cycle as a drain wins,
// so back-to-back Grants never lose an acknowledgement.
module tl_e_slot
  import tl_d_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [SINK_W-1:0] load_sink,
  input  logic              ready,
  output logic              valid,
  output logic [SINK_W-1:0] sink
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      sink  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      sink  <= load_sink;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tl_d_beat_tracker.sv
// Passes TileLink D beats through unchanged, annotates first/last/beat index,
// issues GrantAcks on E for every completed Grant and flags malformed bursts.
module tl_d_beat_tracker
  import tl_d_pkg::*;
#(
  parameter int BEAT_BYTES = 8,
  parameter int MAX_SIZE   = 6,
  parameter int CNT_W      = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  tl_d_beat_tracker_if.slave      bus,
  output logic                    err
);

  if (BEAT_BYTES != (1 << LOG2_BEAT_BYTES)) begin : g_bad_beat_bytes
    $error("BEAT_BYTES must match LOG2_BEAT_BYTES");
  end
  if (CNT_W != MAX_SIZE - LOG2_BEAT_BYTES || CNT_W != 3) begin : g_bad_cnt_w
    $error("CNT_W must equal MAX_SIZE - LOG2_BEAT_BYTES and match the beat port");
  end

  logic [CNT_W-1:0]    cnt;
  logic [OPCODE_W-1:0] burst_opcode;
  logic [SIZE_W-1:0]   burst_size;
  logic [SOURCE_W-1:0] burst_source;
  logic                err_q;

  logic                first;
  logic                last;
  logic [15:0]         beats1;
  logic                is_grant;
  logic                stall;
  logic                fire;
  logic                e_valid;
  logic [SINK_W-1:0]   e_sink;
  logic                bad_size;
  logic                bad_follow;

  // Later beats are sized from the burst header so a corrupted field cannot
  // change the burst length mid-flight.
  assign first  = (cnt == '0);
  assign beats1 = first ? num_beats1(bus.in_d_bits_opcode, bus.in_d_bits_size)
                        : num_beats1(burst_opcode, burst_size);
  assign last   = (beats1 == 16'(cnt));

  assign is_grant = (bus.in_d_bits_opcode == GRANT) || (bus.in_d_bits_opcode == GRANT_DATA);
  assign stall    = is_grant && last && e_valid && !bus.io_e_ready;

  assign bus.in_d_ready  = bus.out_d_ready && !stall;
  assign bus.out_d_valid = bus.in_d_valid && !stall;
  assign fire            = bus.out_d_valid && bus.out_d_ready;

  assign bus.out_d_bits_opcode  = bus.in_d_bits_opcode;
  assign bus.out_d_bits_param   = bus.in_d_bits_param;
  assign bus.out_d_bits_size    = bus.in_d_bits_size;
  assign bus.out_d_bits_source  = bus.in_d_bits_source;
  assign bus.out_d_bits_sink    = bus.in_d_bits_sink;
  assign bus.out_d_bits_denied  = bus.in_d_bits_denied;
  assign bus.out_d_bits_data    = bus.in_d_bits_data;
  assign bus.out_d_bits_corrupt = bus.in_d_bits_corrupt;
  assign bus.out_d_first        = first;
  assign bus.out_d_last         = last;
  assign bus.out_d_beat         = cnt;

  assign bad_size   = bus.in_d_bits_size > SIZE_W'(MAX_SIZE);
  assign bad_follow = !first && ((bus.in_d_bits_opcode != burst_opcode) ||
                                 (bus.in_d_bits_size   != burst_size)   ||
                                 (bus.in_d_bits_source != burst_source));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      burst_opcode <= '0;
      burst_size   <= '0;
      burst_source <= '0;
      err_q        <= 1'b0;
    end else if (fire) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
      if (first) begin
        burst_opcode <= bus.in_d_bits_opcode;
        burst_size   <= bus.in_d_bits_size;
        burst_source <= bus.in_d_bits_source;
      end
      if (bad_size || bad_follow) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;

  tl_e_slot u_e_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (fire && is_grant && last),
    .load_sink (bus.in_d_bits_sink),
    .ready     (bus.io_e_ready),
    .valid     (e_valid),
    .sink      (e_sink)
  );

  assign bus.io_e_valid     = e_valid;
  assign bus.io_e_bits_sink = e_sink;

endmodule
